// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         MUL_LAT_DEF = 4;
    localparam int         DIV_LAT_DEF = 12;

endpackage

// File: rtl/hazard_ctrl_md_tracker.sv
// HI/LO busy tracker: holds busy for exactly LAT cycles after an accepted mult/div issue.
module md_tracker
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic is_div,
    input  logic accept,
    output logic busy,
    output logic done
);

    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);

    md_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done      = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start && accept) begin
                    state_nxt = MD_BUSY;
                    cnt_nxt   = is_div ? DIV_LD : MUL_LD;
                end
            end
            MD_BUSY: begin
                if (cnt == '0) begin
                    done      = 1'b1;
                    state_nxt = MD_IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = MD_IDLE;
        endcase
    end

    assign busy = (state == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / branch-in-ID stalls, taken-branch flush, HI/LO busy.
// Optional performance counters enabled with `define HAZARD_PERF_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_branch,
    input  logic        id_taken,
    input  logic        id_md_start,
    input  logic        id_md_div,
    input  logic        id_hilo_rd,
    input  logic        ex_mem_read,
    input  logic        ex_reg_write,
    input  logic [4:0]  ex_wr_reg,
    input  logic        mem_mem_read,
    input  logic [4:0]  mem_wr_reg,
    output logic        pc_we,
    output logic        fd_we,
    output logic        fd_clr,
    output logic        de_clr,
    output logic        md_busy,
    output logic        md_done
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush,
    output logic [31:0] perf_md_stall
`endif
);

    function automatic logic hit(input logic [4:0] r, input logic [4:0] rs, input logic [4:0] rt);
        return (r != REG_ZERO) && ((r == rs) || (r == rt));
    endfunction

    logic lu_stall, br_stall, md_stall, stall;

    assign lu_stall = ex_mem_read && hit(ex_wr_reg, id_rs, id_rt);
    assign br_stall = id_branch && ((ex_reg_write && hit(ex_wr_reg, id_rs, id_rt)) ||
                                    (mem_mem_read && hit(mem_wr_reg, id_rs, id_rt)));
    assign md_stall = md_busy && (id_hilo_rd || id_md_start);
    assign stall    = lu_stall | br_stall | md_stall;

    md_tracker #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_md (
        .clk    (clk),
        .rst    (rst),
        .start  (id_md_start),
        .is_div (id_md_div),
        .accept (!stall),
        .busy   (md_busy),
        .done   (md_done)
    );

    // A stall holds the unresolved branch in ID, so it suppresses the flush.
    always_comb begin
        pc_we  = 1'b1;
        fd_we  = 1'b1;
        fd_clr = id_taken;
        de_clr = 1'b0;
        if (rst) begin
            pc_we  = 1'b0;
            fd_we  = 1'b0;
            fd_clr = 1'b1;
            de_clr = 1'b1;
        end else if (stall) begin
            pc_we  = 1'b0;
            fd_we  = 1'b0;
            fd_clr = 1'b0;
            de_clr = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall    <= '0;
            perf_flush    <= '0;
            perf_md_stall <= '0;
        end else begin
            if (stall)    perf_stall    <= perf_stall + 32'd1;
            if (fd_clr)   perf_flush    <= perf_flush + 32'd1;
            if (md_stall) perf_md_stall <= perf_md_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: per-cycle expected controls queued at drive, compared at negedge.
module tb_hazard_ctrl;

    typedef struct packed {
        logic pc_we;
        logic fd_we;
        logic fd_clr;
        logic de_clr;
        logic busy;
        logic done;
    } ctl_t;

    localparam ctl_t E_RST   = '{0, 0, 1, 1, 0, 0};
    localparam ctl_t E_RUN   = '{1, 1, 0, 0, 0, 0};
    localparam ctl_t E_FLUSH = '{1, 1, 1, 0, 0, 0};
    localparam ctl_t E_STALL = '{0, 0, 0, 1, 0, 0};
    localparam ctl_t E_MDSTL = '{0, 0, 0, 1, 1, 0};
    localparam ctl_t E_MDDSTL= '{0, 0, 0, 1, 1, 1};
    localparam ctl_t E_BUSY  = '{1, 1, 0, 0, 1, 0};
    localparam ctl_t E_DONE  = '{1, 1, 0, 0, 1, 1};

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_wr_reg, mem_wr_reg;
    logic       id_branch, id_taken, id_md_start, id_md_div, id_hilo_rd;
    logic       ex_mem_read, ex_reg_write, mem_mem_read;
    logic       pc_we, fd_we, fd_clr, de_clr, md_busy, md_done;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall, perf_flush, perf_md_stall;
`endif

    int checks   = 0;
    int failures = 0;

    ctl_t  exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_branch    (id_branch),
        .id_taken     (id_taken),
        .id_md_start  (id_md_start),
        .id_md_div    (id_md_div),
        .id_hilo_rd   (id_hilo_rd),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .ex_wr_reg    (ex_wr_reg),
        .mem_mem_read (mem_mem_read),
        .mem_wr_reg   (mem_wr_reg),
        .pc_we        (pc_we),
        .fd_we        (fd_we),
        .fd_clr       (fd_clr),
        .de_clr       (de_clr),
        .md_busy      (md_busy),
        .md_done      (md_done)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall    (perf_stall),
        .perf_flush    (perf_flush),
        .perf_md_stall (perf_md_stall)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ctl_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, {26'd0, pc_we, fd_we, fd_clr, de_clr, md_busy, md_done}, {26'd0, e});
        end
    end

    task automatic step(input string tag, input ctl_t e);
        tag_q.push_back(tag);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 0; id_rt = 0; id_branch = 0; id_taken = 0;
        id_md_start = 0; id_md_div = 0; id_hilo_rd = 0;
        ex_mem_read = 0; ex_reg_write = 0; ex_wr_reg = 0;
        mem_mem_read = 0; mem_wr_reg = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;

        step("reset0", E_RST);
        step("reset1", E_RST);
        rst = 1'b0;
        step("idle", E_RUN);

        // load-use
        ex_mem_read = 1; ex_wr_reg = 8; id_rs = 8;
        step("lu_rs", E_STALL);
        id_rs = 0; id_rt = 8;
        step("lu_rt", E_STALL);
        ex_wr_reg = 0; id_rt = 0;
        step("lu_reg0", E_RUN);
        ex_wr_reg = 8; id_rs = 7;
        step("lu_nomatch", E_RUN);
        idle_inputs();

        // branch compare in ID
        id_branch = 1; ex_reg_write = 1; ex_wr_reg = 9; id_rt = 9; id_taken = 1;
        step("br_ex_stall", E_STALL);
        ex_reg_write = 0;
        step("br_resolved", E_FLUSH);
        idle_inputs();
        id_branch = 1; mem_mem_read = 1; mem_wr_reg = 3; id_rs = 3;
        step("br_mem_stall", E_STALL);
        id_branch = 0;
        step("nobr_mem_load", E_RUN);
        idle_inputs();
        ex_reg_write = 1; ex_wr_reg = 4; id_rs = 4;
        step("alu_fwd_nostall", E_RUN);
        idle_inputs();
        id_taken = 1;
        step("jump_flush", E_FLUSH);
        idle_inputs();

        // mult then mfhi
        id_md_start = 1; id_md_div = 0;
        step("mul_issue", E_RUN);
        id_md_start = 0; id_hilo_rd = 1;
        step("mul_b1", E_MDSTL);
        step("mul_b2", E_MDSTL);
        step("mul_b3", E_MDSTL);
        step("mul_done", E_MDDSTL);
        step("mfhi_accept", E_RUN);
        idle_inputs();

        // start blocked by load-use, relaunched when clear
        id_md_start = 1; ex_mem_read = 1; ex_wr_reg = 8; id_rs = 8;
        step("start_blocked", E_STALL);
        ex_mem_read = 0;
        step("start_relaunch", E_RUN);
        idle_inputs();
        step("mul2_b1", E_BUSY);
        step("mul2_b2", E_BUSY);
        step("mul2_b3", E_BUSY);
        id_md_start = 1; id_md_div = 1;
        step("div_in_done", E_MDDSTL);
        step("div_accept", E_RUN);
        idle_inputs();
        step("div_b1", E_BUSY);
        step("div_b2", E_BUSY);
        step("div_b3", E_BUSY);
        step("div_b4", E_BUSY);
        rst = 1'b1;
        step("div_abort", E_RST);
        rst = 1'b0;
        step("post_abort0", E_RUN);
        id_hilo_rd = 1;
        step("post_abort_mfhi", E_RUN);
        idle_inputs();
        step("post_abort2", E_RUN);

`ifdef HAZARD_PERF_EN
        rst = 1'b1;
        step("perf_rst", E_RST);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ex_mem_read = 1; ex_wr_reg = 5'(10 + i); id_rs = 5'(10 + i);
            step("perf_lu", E_STALL);
        end
        idle_inputs();
        id_taken = 1;
        step("perf_br0", E_FLUSH);
        step("perf_br1", E_FLUSH);
        idle_inputs();
        step("perf_idle", E_RUN);
        @(negedge clk);
        chk("perf_stall", perf_stall, 32'd3);
        chk("perf_flush", perf_flush, 32'd2);
        chk("perf_md_stall", perf_md_stall, 32'd0);
`endif

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
